ysyx_25060170_commit_queue: RTL and testbench

YSYX_25060170_COMMIT_QUEUE -- requirements
Module: ysyx_25060170_commit_queue

---
 rtl/ysyx_25060170_commit_queue_pkg.sv | 13 +
 rtl/ysyx_25060170_define.sv | 11 +
 rtl/ysyx_25060170_sync_fifo.sv | 61 ++++++
 rtl/ysyx_25060170_commit_queue.sv | 79 +++++++
 tb/tb_ysyx_25060170_commit_queue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060170_commit_queue_pkg.sv
// Types shared by the commit queue and its storage FIFO.
`include "ysyx_25060170_define.sv"

package ysyx_25060170_commit_queue_pkg;

    typedef enum logic {
        CQ_RUN  = `ysyx_25060170_CQ_RUN,
        CQ_HALT = `ysyx_25060170_CQ_HALT
    } cq_state_e;

    localparam int unsigned CNT_W = 64;

endpackage

// File: rtl/ysyx_25060170_define.sv
// Shared macro definitions for the ysyx_25060170 core: reset level, trap encoding
// and commit-queue state encodings.
`ifndef YSYX_25060170_DEFINE_SV
`define YSYX_25060170_DEFINE_SV

`define ysyx_25060170_RSTABLE 1'b0
`define EBREAK_TRAP           32'h00100073
`define ysyx_25060170_CQ_RUN  1'b0
`define ysyx_25060170_CQ_HALT 1'b1

`endif

// File: rtl/ysyx_25060170_sync_fifo.sv
// Registered-output-free synchronous FIFO; head entry read directly from storage,
// so a write becomes visible only after the pointer update at the next edge.
`include "ysyx_25060170_define.sv"

module ysyx_25060170_sync_fifo
    import ysyx_25060170_commit_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign rdata = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == `ysyx_25060170_RSTABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (do_push && (rst != `ysyx_25060170_RSTABLE))
            mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/ysyx_25060170_commit_queue.sv
// Commit-to-trace queue: buffers retired instructions for a trace consumer,
// stops accepting after an ebreak is handed over, and counts handed-over entries.
`include "ysyx_25060170_define.sv"

module ysyx_25060170_commit_queue
    import ysyx_25060170_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmt_valid_i,
    input  logic [XLEN-1:0]  cmt_pc_i,
    input  logic [XLEN-1:0]  cmt_inst_i,
    output logic             cmt_ready_o,
    output logic             trc_valid_o,
    output logic [XLEN-1:0]  trc_pc_o,
    output logic [XLEN-1:0]  trc_inst_o,
    input  logic             trc_ready_i,
    output logic             trc_ebreak_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    cq_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [2*XLEN-1:0]  head;

    ysyx_25060170_sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({cmt_pc_i, cmt_inst_i}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready depends only on registered state, never on trc_ready_i.
    assign cmt_ready_o   = !fifo_full && (state_q == CQ_RUN);
    assign trc_valid_o   = !fifo_empty;
    assign trc_pc_o      = head[2*XLEN-1:XLEN];
    assign trc_inst_o    = head[XLEN-1:0];
    assign trc_ebreak_o  = (trc_inst_o == XLEN'(`EBREAK_TRAP));
    assign halt_o        = (state_q == CQ_HALT);
    assign retired_cnt_o = cnt_q;

    assign push = cmt_valid_i && cmt_ready_o;
    assign pop  = trc_valid_o && trc_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 1'b1;
            if (trc_ebreak_o) state_d = CQ_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == `ysyx_25060170_RSTABLE) begin
            state_q <= CQ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_commit_queue.sv
// Bench for the commit queue: fixed vector table, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_ysyx_25060170_commit_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] EBRK  = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid_i;
    logic [31:0] cmt_pc_i;
    logic [31:0] cmt_inst_i;
    logic        cmt_ready_o;
    logic        trc_valid_o;
    logic [31:0] trc_pc_o;
    logic [31:0] trc_inst_o;
    logic        trc_ready_i;
    logic        trc_ebreak_o;
    logic        halt_o;
    logic [63:0] retired_cnt_o;

    always #5 clk = ~clk;

    ysyx_25060170_commit_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmt_valid_i   (cmt_valid_i),
        .cmt_pc_i      (cmt_pc_i),
        .cmt_inst_i    (cmt_inst_i),
        .cmt_ready_o   (cmt_ready_o),
        .trc_valid_o   (trc_valid_o),
        .trc_pc_o      (trc_pc_o),
        .trc_inst_o    (trc_inst_o),
        .trc_ready_i   (trc_ready_i),
        .trc_ebreak_o  (trc_ebreak_o),
        .halt_o        (halt_o),
        .retired_cnt_o (retired_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc, inst}, a halted flag and a counter.
    logic [63:0] mq[$];
    bit          m_halt;
    logic [63:0] m_cnt;

    task automatic model_step(input logic r, input logic cv, input logic [31:0] pc,
                              input logic [31:0] inst, input logic tr);
        logic [63:0] h;
        bit accept;
        if (!r) begin
            mq.delete();
            m_halt = 0;
            m_cnt  = '0;
        end else begin
            accept = cv && (mq.size() < DEPTH) && !m_halt;
            if (mq.size() > 0 && tr) begin
                h = mq.pop_front();
                m_cnt++;
                if (h[31:0] == EBRK) m_halt = 1;
            end
            if (accept) mq.push_back({pc, inst});
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".cmt_ready"}, 64'(cmt_ready_o), 64'((mq.size() < DEPTH) && !m_halt));
        chk({tag, ".trc_valid"}, 64'(trc_valid_o), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk({tag, ".trc_pc"},     64'(trc_pc_o),     64'(mq[0][63:32]));
            chk({tag, ".trc_inst"},   64'(trc_inst_o),   64'(mq[0][31:0]));
            chk({tag, ".trc_ebreak"}, 64'(trc_ebreak_o), 64'(mq[0][31:0] == EBRK));
        end
        chk({tag, ".halt"},    64'(halt_o), 64'(m_halt));
        chk({tag, ".retired"}, retired_cnt_o, m_cnt);
    endtask

    // Inputs change at the falling edge; outputs sampled at the next falling edge.
    task automatic apply(input logic r, input logic cv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic tr);
        rst = r; cmt_valid_i = cv; cmt_pc_i = pc; cmt_inst_i = inst; trc_ready_i = tr;
        @(posedge clk);
        @(negedge clk);
        model_step(r, cv, pc, inst, tr);
    endtask

    task automatic cyc(input string tag, input logic r, input logic cv,
                       input logic [31:0] pc, input logic [31:0] inst, input logic tr);
        apply(r, cv, pc, inst, tr);
        model_check(tag);
    endtask

    typedef struct {
        logic        rst_n, cv;
        logic [31:0] pc, inst;
        logic        tr;
        logic        e_rdy, e_vld;
        logic [31:0] e_pc, e_inst;
        logic        e_ebk, e_halt;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vt[9];

    function automatic vec_t mk(logic r, logic cv, logic [31:0] pc, logic [31:0] inst, logic tr,
                                logic rdy, logic vld, logic [31:0] epc, logic [31:0] einst,
                                logic ebk, logic hlt, logic [63:0] cnt);
        vec_t v;
        v.rst_n = r; v.cv = cv; v.pc = pc; v.inst = inst; v.tr = tr;
        v.e_rdy = rdy; v.e_vld = vld; v.e_pc = epc; v.e_inst = einst;
        v.e_ebk = ebk; v.e_halt = hlt; v.e_cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [31:0] hold_pc, hold_inst;

        //             rst cv pc            inst          tr  rdy vld e_pc          e_inst        ebk hlt cnt
        vt[0] = mk(0, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        32'h0,        0, 0, 0);
        vt[1] = mk(1, 1, 32'h80000000, 32'h00000413, 1,  1, 1, 32'h80000000, 32'h00000413, 0, 0, 0);
        vt[2] = mk(1, 0, 32'h0,        32'h0,        1,  1, 0, 32'h0,        32'h0,        0, 0, 1);
        vt[3] = mk(1, 1, 32'h80000004, EBRK,         0,  1, 1, 32'h80000004, EBRK,         1, 0, 1);
        vt[4] = mk(1, 1, 32'h80000008, 32'h00000013, 0,  1, 1, 32'h80000004, EBRK,         1, 0, 1);
        vt[5] = mk(1, 0, 32'h0,        32'h0,        1,  0, 1, 32'h80000008, 32'h00000013, 0, 1, 2);
        vt[6] = mk(1, 1, 32'h8000000c, 32'h00000093, 0,  0, 1, 32'h80000008, 32'h00000013, 0, 1, 2);
        vt[7] = mk(1, 0, 32'h0,        32'h0,        1,  0, 0, 32'h0,        32'h0,        0, 1, 3);
        vt[8] = mk(0, 0, 32'h0,        32'h0,        0,  1, 0, 32'h0,        32'h0,        0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            apply(vt[i].rst_n, vt[i].cv, vt[i].pc, vt[i].inst, vt[i].tr);
            chk($sformatf("vec%0d.cmt_ready", i), 64'(cmt_ready_o), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d.trc_valid", i), 64'(trc_valid_o), 64'(vt[i].e_vld));
            if (vt[i].e_vld) begin
                chk($sformatf("vec%0d.trc_pc", i),     64'(trc_pc_o),     64'(vt[i].e_pc));
                chk($sformatf("vec%0d.trc_inst", i),   64'(trc_inst_o),   64'(vt[i].e_inst));
                chk($sformatf("vec%0d.trc_ebreak", i), 64'(trc_ebreak_o), 64'(vt[i].e_ebk));
            end
            chk($sformatf("vec%0d.halt", i),    64'(halt_o), 64'(vt[i].e_halt));
            chk($sformatf("vec%0d.retired", i), retired_cnt_o, vt[i].e_cnt);
        end

        // Fill to full, attempt a fifth push, then drain in order.
        cyc("fill.rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("fill.push%0d", i), 1, 1, 32'h80001000 + 32'(4*i), 32'h00a00013 + 32'(i), 0);
        chk("fill.ready_low", 64'(cmt_ready_o), 64'd0);
        cyc("fill.push5", 1, 1, 32'hdeadbeef, 32'h12345678, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill.order%0d", i), 64'(trc_pc_o), 64'(32'h80001000 + 32'(4*i)));
            cyc($sformatf("fill.pop%0d", i), 1, 0, 0, 0, 1);
        end
        chk("fill.empty", 64'(trc_valid_o), 64'd0);

        // Two entries resident, then 10 cycles of simultaneous push and pop.
        cyc("flow.rst", 0, 0, 0, 0, 0);
        cyc("flow.pre0", 1, 1, 32'h80002000, 32'h00100093, 0);
        cyc("flow.pre1", 1, 1, 32'h80002004, 32'h00200093, 0);
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("flow.pp%0d", i), 1, 1, 32'h80002008 + 32'(4*i), 32'h00300093 + 32'(i), 1);
            chk($sformatf("flow.occ%0d", i), 64'(mq.size()), 64'd2);
            chk($sformatf("flow.head%0d", i), 64'(trc_pc_o), 64'(32'h80002000 + 32'(4*(i+1))));
        end
        cyc("flow.drain0", 1, 0, 0, 0, 1);
        cyc("flow.drain1", 1, 0, 0, 0, 1);
        chk("flow.retired", retired_cnt_o, 64'd12);

        // Ebreak followed by two entries: halt, block commits, keep draining.
        cyc("halt.rst", 0, 0, 0, 0, 0);
        cyc("halt.ebk", 1, 1, 32'h80003000, EBRK, 0);
        cyc("halt.e1",  1, 1, 32'h80003004, 32'h00000013, 0);
        cyc("halt.e2",  1, 1, 32'h80003008, 32'h00000013, 0);
        cyc("halt.pop_ebk", 1, 0, 0, 0, 1);
        chk("halt.halt_next", 64'(halt_o), 64'd1);
        cyc("halt.pop1", 1, 1, 32'h8000300c, 32'h00000013, 1);
        chk("halt.blocked", 64'(cmt_ready_o), 64'd0);
        cyc("halt.pop2", 1, 1, 32'h80003010, 32'h00000013, 1);
        chk("halt.drained", 64'(trc_valid_o), 64'd0);
        chk("halt.count", retired_cnt_o, 64'd3);

        // Reset with three queued entries, push and pop requested in that cycle.
        cyc("mrst.rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("mrst.push%0d", i), 1, 1, 32'h80004000 + 32'(4*i), 32'h00000513, 0);
        cyc("mrst.assert", 0, 1, 32'h80004100, 32'h00000513, 1);
        chk("mrst.valid", 64'(trc_valid_o), 64'd0);
        chk("mrst.ready", 64'(cmt_ready_o), 64'd1);

        // Head stays stable while the consumer stalls, even as commits arrive.
        cyc("stall.push", 1, 1, 32'h80005000, 32'h00b00593, 0);
        hold_pc   = trc_pc_o;
        hold_inst = trc_inst_o;
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("stall.c%0d", i), 1, 1, 32'h80005100 + 32'(4*i), 32'h00c00613, 0);
            chk($sformatf("stall.pc%0d", i),   64'(trc_pc_o),   64'(hold_pc));
            chk($sformatf("stall.inst%0d", i), 64'(trc_inst_o), 64'(hold_inst));
        end

        // Random traffic against the model.
        cyc("rnd.rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic        r, cv, tr;
            logic [31:0] pc, inst;
            r    = ($urandom_range(0, 63) != 0);
            cv   = ($urandom_range(0, 3) != 0);
            tr   = ($urandom_range(0, 2) != 0);
            pc   = $urandom;
            inst = ($urandom_range(0, 15) == 0) ? EBRK : $urandom;
            cyc($sformatf("rnd%0d", i), r, cv, pc, inst, tr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
